// File: rtl/pcie.sv
// pcie: PIPE/LPIF shim with a compact LTSSM (detect, TS1/TS2 training, rate change, EQ when PCIE_EQ_EN is defined, L0 data).
module pcie #(
    parameter int MAXPIPEWIDTH   = 32,
    parameter int DEVICETYPE     = 0,
    parameter int LANESNUMBER    = 16,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int MAX_GEN        = 1
) (
    input  logic CLK,
    input  logic reset,
    output logic phy_reset,
    output logic [1:0] width,
    output logic [MAXPIPEWIDTH*LANESNUMBER-1:0] TxData,
    output logic [LANESNUMBER-1:0] TxDataValid,
    output logic [LANESNUMBER-1:0] TxElecIdle,
    output logic [LANESNUMBER-1:0] TxStartBlock,
    output logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] TxDataK,
    output logic [2*LANESNUMBER-1:0] TxSyncHeader,
    output logic [LANESNUMBER-1:0] TxDetectRx_Loopback,
    input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0] RxData,
    input  logic [LANESNUMBER-1:0] RxDataValid,
    input  logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] RxDataK,
    input  logic [LANESNUMBER-1:0] RxStartBlock,
    input  logic [2*LANESNUMBER-1:0] RxSyncHeader,
    input  logic [3*LANESNUMBER-1:0] RxStatus,
    input  logic [15:0] RxElectricalIdle,
    output logic [4*LANESNUMBER-1:0] PowerDown,
    output logic [3:0] Rate,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    output logic [4:0] PCLKRate,
    output logic PclkChangeAck,
    input  logic PclkChangeOk,
    input  logic [18*LANESNUMBER-1:0] LocalTxPresetCoefficients,
    output logic [18*LANESNUMBER-1:0] TxDeemph,
    input  logic [6*LANESNUMBER-1:0] LocalFS,
    input  logic [6*LANESNUMBER-1:0] LocalLF,
    output logic [4*LANESNUMBER-1:0] LocalPresetIndex,
    output logic [LANESNUMBER-1:0] GetLocalPresetCoeffcients,
    input  logic [LANESNUMBER-1:0] LocalTxCoefficientsValid,
    output logic [6*LANESNUMBER-1:0] LF,
    output logic [6*LANESNUMBER-1:0] FS,
    output logic [LANESNUMBER-1:0] RxEqEval,
    output logic [LANESNUMBER-1:0] InvalidRequest,
    input  logic [6*LANESNUMBER-1:0] LinkEvaluationFeedbackDirectionChange,
    output logic pl_trdy,
    input  logic lp_irdy,
    input  logic [511:0] lp_data,
    input  logic [63:0] lp_valid,
    output logic [511:0] pl_data,
    output logic [63:0] pl_valid,
    input  logic [3:0] lp_state_req,
    output logic [3:0] pl_state_sts,
    output logic [2:0] pl_speedmode,
    input  logic lp_force_detect,
    input  logic [63:0] lp_dlpstart,
    input  logic [63:0] lp_dlpend,
    input  logic [63:0] lp_tlpstart,
    input  logic [63:0] lp_tlpend,
    output logic [63:0] pl_dlpstart,
    output logic [63:0] pl_dlpend,
    output logic [63:0] pl_tlpstart,
    output logic [63:0] pl_tlpend,
    output logic [63:0] pl_tlpedb,
    output logic pl_linkUp,
    output logic [7:0] M2P_MessageBus,
    input  logic [7:0] P2M_MessageBus,
    output logic [15:0] RxStandby
);
    localparam int L = LANESNUMBER;
    localparam int DW = MAXPIPEWIDTH * LANESNUMBER;
    localparam int KW = MAXPIPEWIDTH / 8 * LANESNUMBER;
    localparam logic [2:0] DETECT = 3'd0, POLLING = 3'd1, CONFIG = 3'd2, SPEED = 3'd3, EQ = 3'd4, L0 = 3'd5;
    localparam logic [31:0] TS1 = 32'h4A4A4ABC, TS2 = 32'h454545BC;

    logic [2:0] state, stateNext, cur;
    logic [3:0] cnt, rate;
    logic detReg, txBeat, txOn, inL0, leaving, goL0, tsMatch, reached, accept, rxTake;
    logic [DW-1:0] txDataReg;
    logic [KW-1:0] txKReg;
    logic [511:0] plDataReg;
    logic [63:0] plValidReg, tlpStartReg, tlpEndReg, lowBit, highBit;
    logic eqDone, eqEval;
    logic unused;

    // Outputs decode from cur so a synchronous reset drops the link in the same cycle.
    assign cur = reset ? DETECT : state;
    assign inL0 = cur == L0;
    assign leaving = lp_force_detect || lp_state_req == 4'd2;
    assign goL0 = lp_state_req == 4'd1;
    assign tsMatch = RxData == (state == POLLING ? {L{TS1}} : {L{TS2}});
    assign reached = cnt == 4'd8 || (cnt == 4'd7 && tsMatch);
    assign accept = inL0 && lp_irdy && !leaving;
    assign rxTake = inL0 && !leaving && &RxDataValid && &RxStartBlock;
    assign txOn = txBeat && !reset;

    always_comb begin
        stateNext = state;
        case (state)
            DETECT:  if (detReg && &PhyStatus && RxStatus == {L{3'b011}}) stateNext = POLLING;
            POLLING: if (reached) stateNext = CONFIG;
            CONFIG:  if (reached && (MAX_GEN > 1 || goL0)) stateNext = MAX_GEN > 1 ? SPEED : L0;
`ifdef PCIE_EQ_EN
            SPEED:   if (cnt >= 4'd3) stateNext = EQ;
            EQ:      if (eqDone && goL0) stateNext = L0;
`else
            SPEED:   if (cnt >= 4'd3 && goL0) stateNext = L0;
`endif
            L0:      if (leaving) stateNext = DETECT;
            default: stateNext = DETECT;
        endcase
    end

    always_comb begin
        highBit = '0;
        for (int i = 0; i < 64; i++) if (RxDataK[i]) highBit = 64'd1 << i;
    end
    assign lowBit = RxDataK & (~RxDataK + 64'd1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= DETECT;
            cnt <= '0;
            rate <= '0;
            detReg <= 1'b0;
            txBeat <= 1'b0;
            txDataReg <= '0;
            txKReg <= '0;
            plDataReg <= '0;
            plValidReg <= '0;
            tlpStartReg <= '0;
            tlpEndReg <= '0;
        end else begin
            state <= stateNext;
            // Training counters saturate at 8 so a state gated by lp_state_req keeps its result.
            cnt <= stateNext != state ? 4'd0
                 : (state == POLLING || state == CONFIG) ? (cnt == 4'd8 ? cnt : tsMatch ? cnt + 4'd1 : 4'd0)
                 : cnt == 4'd15 ? cnt : cnt + 4'd1;
            rate <= stateNext == SPEED ? 4'(MAX_GEN - 1) : stateNext == DETECT ? 4'd0 : rate;
            detReg <= stateNext == DETECT;
            txBeat <= accept;
            txDataReg <= accept ? lp_data : txDataReg;
            txKReg <= accept ? lp_valid : txKReg;
            plDataReg <= rxTake ? RxData : plDataReg;
            plValidReg <= rxTake ? RxDataK : '0;
            tlpStartReg <= rxTake ? lowBit : '0;
            tlpEndReg <= rxTake ? highBit : '0;
        end
    end

`ifdef PCIE_EQ_EN
    logic eqLatch;
    logic [18*L-1:0] deemphReg;
    logic [6*L-1:0] lfReg, fsReg;
    assign eqLatch = cur == EQ && !eqDone && &LocalTxCoefficientsValid;
    always_ff @(posedge CLK) begin
        if (reset) begin
            eqDone <= 1'b0;
            eqEval <= 1'b0;
            deemphReg <= '0;
            lfReg <= '0;
            fsReg <= '0;
        end else begin
            eqDone <= state == EQ && (eqDone || eqLatch);
            eqEval <= eqLatch;
            deemphReg <= eqLatch ? LocalTxPresetCoefficients : deemphReg;
            lfReg <= eqLatch ? LocalLF : lfReg;
            fsReg <= eqLatch ? LocalFS : fsReg;
        end
    end
    assign GetLocalPresetCoeffcients = {L{cur == EQ && !eqDone}};
    assign LocalPresetIndex = cur == EQ ? {L{4'd4}} : '0;
    assign RxEqEval = {L{eqEval}};
    assign TxDeemph = deemphReg;
    assign LF = lfReg;
    assign FS = fsReg;
`else
    logic unusedEq;
    assign eqDone = 1'b0;
    assign eqEval = 1'b0;
    assign unusedEq = ^{LocalTxPresetCoefficients, LocalLF, LocalFS, LocalTxCoefficientsValid, EQ, eqDone, eqEval};
    assign GetLocalPresetCoeffcients = '0;
    assign LocalPresetIndex = '0;
    assign RxEqEval = '0;
    assign TxDeemph = '0;
    assign LF = '0;
    assign FS = '0;
`endif

    assign phy_reset = reset;
    assign width = 2'b10;
    assign TxData = cur == POLLING ? {L{TS1}} : cur == CONFIG ? {L{TS2}} : txOn ? txDataReg : '0;
    assign TxDataK = (cur == POLLING || cur == CONFIG) ? {L{4'b0001}} : txOn ? txKReg : '0;
    assign TxDataValid = {L{txOn}};
    assign TxStartBlock = {L{txOn}};
    assign TxSyncHeader = txOn ? {L{2'b10}} : '0;
    assign TxElecIdle = {L{cur == DETECT}};
    assign TxDetectRx_Loopback = {L{detReg}};
    assign PowerDown = cur == DETECT ? {L{4'd2}} : '0;
    assign Rate = rate;
    assign PCLKRate = {1'b0, rate};
    assign PclkChangeAck = cur == SPEED && cnt == 4'd0;
    assign InvalidRequest = '0;
    assign pl_trdy = inL0;
    assign pl_linkUp = inL0;
    assign pl_state_sts = {3'b000, inL0};
    assign pl_speedmode = inL0 ? rate[2:0] : 3'd0;
    assign pl_data = plDataReg;
    assign pl_valid = plValidReg;
    assign pl_tlpstart = tlpStartReg;
    assign pl_tlpend = tlpEndReg;
    assign pl_dlpstart = '0;
    assign pl_dlpend = '0;
    assign pl_tlpedb = '0;
    assign M2P_MessageBus = '0;
    assign RxStandby = '0;
    assign unused = ^{RxSyncHeader, RxElectricalIdle, PclkChangeOk, LinkEvaluationFeedbackDirectionChange,
                      lp_dlpstart, lp_dlpend, lp_tlpstart, lp_tlpend, P2M_MessageBus,
                      32'(DEVICETYPE), 32'(GEN1_PIPEWIDTH), 32'(GEN2_PIPEWIDTH), 32'(GEN3_PIPEWIDTH),
                      32'(GEN4_PIPEWIDTH), 32'(GEN5_PIPEWIDTH)};
endmodule

// File: tb/tb_pcie.sv
// tb_pcie: directed bench for pcie with Tx looped back to Rx; expectations adapt to PCIE_EQ_EN.
module tb_pcie;
    localparam logic [31:0] TS1 = 32'h4A4A4ABC, TS2 = 32'h454545BC;

    logic CLK = 1'b0, reset = 1'b1;
    logic phy_reset;
    logic [1:0] width;
    logic [511:0] TxData;
    logic [15:0] TxDataValid, TxElecIdle, TxStartBlock, TxDetectRx_Loopback;
    logic [63:0] TxDataK;
    logic [31:0] TxSyncHeader;
    logic [47:0] RxStatus = '0;
    logic [15:0] RxElectricalIdle = '0;
    logic [63:0] PowerDown;
    logic [3:0] Rate;
    logic [15:0] PhyStatus = '0;
    logic [4:0] PCLKRate;
    logic PclkChangeAck;
    logic PclkChangeOk = 1'b0;
    logic [287:0] LocalTxPresetCoefficients = {288{1'b1}};
    logic [287:0] TxDeemph;
    logic [95:0] LocalFS = {96{1'b1}}, LocalLF = {96{1'b1}}, LF, FS, LinkEval = '0;
    logic [63:0] LocalPresetIndex;
    logic [15:0] GetLocalPresetCoeffcients, RxEqEval, InvalidRequest;
    logic [15:0] LocalTxCoefficientsValid = '0;
    logic pl_trdy, lp_irdy = 1'b0, lp_force_detect = 1'b0, pl_linkUp;
    logic [511:0] lp_data = '0, pl_data;
    logic [63:0] lp_valid = '0, pl_valid;
    logic [3:0] lp_state_req = '0, pl_state_sts;
    logic [2:0] pl_speedmode;
    logic [63:0] lpFrame = '0;
    logic [63:0] pl_dlpstart, pl_dlpend, pl_tlpstart, pl_tlpend, pl_tlpedb;
    logic [7:0] M2P_MessageBus, P2M_MessageBus = '0;
    logic [15:0] RxStandby;

    int total = 0, bad = 0;

    always #5 CLK = ~CLK;

    pcie #(.MAX_GEN(5)) dut (
        .CLK(CLK), .reset(reset), .phy_reset(phy_reset), .width(width),
        .TxData(TxData), .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle), .TxStartBlock(TxStartBlock),
        .TxDataK(TxDataK), .TxSyncHeader(TxSyncHeader), .TxDetectRx_Loopback(TxDetectRx_Loopback),
        .RxData(TxData), .RxDataValid(TxDataValid), .RxDataK(TxDataK), .RxStartBlock(TxStartBlock),
        .RxSyncHeader(TxSyncHeader), .RxStatus(RxStatus), .RxElectricalIdle(RxElectricalIdle),
        .PowerDown(PowerDown), .Rate(Rate), .PhyStatus(PhyStatus), .PCLKRate(PCLKRate),
        .PclkChangeAck(PclkChangeAck), .PclkChangeOk(PclkChangeOk),
        .LocalTxPresetCoefficients(LocalTxPresetCoefficients), .TxDeemph(TxDeemph),
        .LocalFS(LocalFS), .LocalLF(LocalLF), .LocalPresetIndex(LocalPresetIndex),
        .GetLocalPresetCoeffcients(GetLocalPresetCoeffcients), .LocalTxCoefficientsValid(LocalTxCoefficientsValid),
        .LF(LF), .FS(FS), .RxEqEval(RxEqEval), .InvalidRequest(InvalidRequest),
        .LinkEvaluationFeedbackDirectionChange(LinkEval),
        .pl_trdy(pl_trdy), .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
        .pl_data(pl_data), .pl_valid(pl_valid), .lp_state_req(lp_state_req), .pl_state_sts(pl_state_sts),
        .pl_speedmode(pl_speedmode), .lp_force_detect(lp_force_detect),
        .lp_dlpstart(lpFrame), .lp_dlpend(lpFrame), .lp_tlpstart(lpFrame), .lp_tlpend(lpFrame),
        .pl_dlpstart(pl_dlpstart), .pl_dlpend(pl_dlpend), .pl_tlpstart(pl_tlpstart), .pl_tlpend(pl_tlpend),
        .pl_tlpedb(pl_tlpedb), .pl_linkUp(pl_linkUp), .M2P_MessageBus(M2P_MessageBus),
        .P2M_MessageBus(P2M_MessageBus), .RxStandby(RxStandby)
    );

    typedef struct {
        logic irdy;
        logic [63:0] valid;
        logic [63:0] expStart;
        logic [63:0] expEnd;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic waitLink(input string nm);
        int n = 0;
        while (pl_linkUp !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk(nm, pl_linkUp, 1);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [511:0] d;
        vecs[0] = '{1'b1, 64'h3FFF_FFFF_FFFF_FFFF, 64'h1, 64'h2000_0000_0000_0000};
        vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        vecs[2] = '{1'b1, 64'h1, 64'h1, 64'h1};
        vecs[3] = '{1'b1, 64'hF0, 64'h10, 64'h80};
        vecs[4] = '{1'b1, 64'h8000_0000_0000_0001, 64'h1, 64'h8000_0000_0000_0000};
        vecs[5] = '{1'b1, 64'h0, 64'h0, 64'h0};
        vecs[6] = '{1'b1, 64'h0001_0000_0100_0000, 64'h0100_0000, 64'h0001_0000_0000_0000};

        step(3);
        chk("rst_sts", pl_state_sts, 0);
        chk("rst_link", pl_linkUp, 0);
        chk("rst_elecidle", TxElecIdle, 16'hFFFF);
        chk("rst_rate", Rate, 0);
        chk("rst_detect", TxDetectRx_Loopback, 0);
        chk("rst_txvalid", TxDataValid, 0);
        chk("rst_phyreset", phy_reset, 1);
        chk("width", width, 2'b10);

        PhyStatus = 16'hFFFF;
        RxStatus = {16{3'b011}};
        reset = 1'b0;
        step(1);
        chk("det_loopback", TxDetectRx_Loopback, 16'hFFFF);
        chk("det_powerdown", PowerDown, {16{4'd2}});
        step(1);
        chk("poll_ts1", TxData, {16{TS1}});
        chk("poll_k", TxDataK, {16{4'b0001}});
        chk("poll_elecidle", TxElecIdle, 0);
        chk("poll_powerdown", PowerDown, 0);
        step(7);
        chk("poll_ts1_hold", TxData, {16{TS1}});
        step(1);
        chk("cfg_ts2", TxData, {16{TS2}});
        step(8);
        chk("spd_ack", PclkChangeAck, 1);
        chk("spd_rate", Rate, 4);
        chk("spd_pclkrate", PCLKRate, 4);
        step(1);
        chk("spd_ack_pulse", PclkChangeAck, 0);
        step(3);
`ifdef PCIE_EQ_EN
        chk("eq_getcoef", GetLocalPresetCoeffcients, 16'hFFFF);
        chk("eq_presetidx", LocalPresetIndex, {16{4'd4}});
        chk("eq_deemph_pre", TxDeemph, 0);
`else
        chk("noeq_getcoef", GetLocalPresetCoeffcients, 0);
`endif
        LocalTxCoefficientsValid = 16'hFFFF;
        step(1);
`ifdef PCIE_EQ_EN
        chk("eq_deemph", TxDeemph, {288{1'b1}});
        chk("eq_lf", LF, {96{1'b1}});
        chk("eq_fs", FS, {96{1'b1}});
        chk("eq_eval", RxEqEval, 16'hFFFF);
        chk("eq_getcoef_off", GetLocalPresetCoeffcients, 0);
`else
        chk("noeq_deemph", TxDeemph, 0);
        chk("noeq_lf", LF, 0);
        chk("noeq_eval", RxEqEval, 0);
        chk("noeq_getcoef2", GetLocalPresetCoeffcients, 0);
`endif
        step(1);
        chk("eval_pulse", RxEqEval, 0);
        chk("wait_req_link", pl_linkUp, 0);
        chk("wait_req_trdy", pl_trdy, 0);
        lp_state_req = 4'd1;
        step(1);
        chk("l0_link", pl_linkUp, 1);
        chk("l0_speed", pl_speedmode, 4);
        chk("l0_sts", pl_state_sts, 1);
        chk("l0_trdy", pl_trdy, 1);
        chk("l0_idle_txdata", TxData, 0);

        for (int v = 0; v < 7; v++) begin
            d = rnd512();
            lp_irdy = vecs[v].irdy;
            lp_data = d;
            lp_valid = vecs[v].valid;
            step(1);
            lp_irdy = 1'b0;
            lp_data = '0;
            lp_valid = '0;
            chk($sformatf("tx_valid_%0d", v), TxDataValid, vecs[v].irdy ? 16'hFFFF : 16'h0);
            if (vecs[v].irdy) begin
                chk($sformatf("tx_data_%0d", v), TxData, d);
                chk($sformatf("tx_k_%0d", v), TxDataK, vecs[v].valid);
                chk($sformatf("tx_sync_%0d", v), TxSyncHeader, {16{2'b10}});
            end
            step(1);
            chk($sformatf("rx_valid_%0d", v), pl_valid, vecs[v].irdy ? vecs[v].valid : 64'h0);
            chk($sformatf("rx_start_%0d", v), pl_tlpstart, vecs[v].expStart);
            chk($sformatf("rx_end_%0d", v), pl_tlpend, vecs[v].expEnd);
            if (vecs[v].irdy) chk($sformatf("rx_data_%0d", v), pl_data, d);
        end
        chk("dlp_zero", {pl_dlpstart, pl_dlpend, pl_tlpedb}, 0);

        lp_force_detect = 1'b1;
        lp_irdy = 1'b1;
        lp_valid = {64{1'b1}};
        lp_data = rnd512();
        step(1);
        lp_force_detect = 1'b0;
        lp_irdy = 1'b0;
        chk("fd_link", pl_linkUp, 0);
        chk("fd_loopback", TxDetectRx_Loopback, 16'hFFFF);
        chk("fd_txvalid", TxDataValid, 0);
        chk("fd_sts", pl_state_sts, 0);
        waitLink("retrain_fd");
        chk("retrain_speed", pl_speedmode, 4);

        lp_state_req = 4'd2;
        step(1);
        chk("req2_link", pl_linkUp, 0);
        chk("req2_powerdown", PowerDown, {16{4'd2}});
        lp_state_req = 4'd1;
        waitLink("retrain_req2");

        reset = 1'b1;
        #1;
        chk("midrst_link", pl_linkUp, 0);
        chk("midrst_trdy", pl_trdy, 0);
        chk("midrst_elecidle", TxElecIdle, 16'hFFFF);
        step(1);
        chk("midrst_loopback", TxDetectRx_Loopback, 0);
        chk("midrst_rate", Rate, 0);
        reset = 1'b0;
        step(1);
        chk("post_rst_loopback", TxDetectRx_Loopback, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie.md
PCIE -- requirements
Module: pcie

Interface
REQ-001 Params SHALL be: MAXPIPEWIDTH (W) 32, per-lane PIPE bits; DEVICETYPE 0, 0 downstream/1 upstream, no functional effect; LANESNUMBER (L) 16, lane count; GEN1..GEN5_PIPEWIDTH 8, informational only; MAX_GEN 1, target generation 1..5.
REQ-002 Ports SHALL be in exactly this positional order.
REQ-003 The block SHALL use one clock and a synchronous active-high reset: CLK in 1, clock; reset in 1, synchronous active-high reset.
REQ-004 PHY control ports SHALL be: phy_reset out 1 (equals reset); width out 2 (constant 2'b10).
REQ-005 PIPE Tx ports SHALL be: TxData out W*L; TxDataValid, TxElecIdle, TxStartBlock out L each; TxDataK out (W/8)*L; TxSyncHeader out 2L; TxDetectRx_Loopback out L.
REQ-006 PIPE Rx ports SHALL be: RxData in W*L; RxDataValid in L; RxDataK in (W/8)*L; RxStartBlock in L; RxSyncHeader in 2L; RxStatus in 3L; RxElectricalIdle in 16 (ignored).
REQ-007 PHY command/status ports SHALL be: PowerDown out 4L; Rate out 4; PhyStatus in L; PCLKRate out 5; PclkChangeAck out 1; PclkChangeOk in 1 (ignored).
REQ-008 Equalization ports SHALL be: LocalTxPresetCoefficients in 18L; TxDeemph out 18L; LocalFS, LocalLF in 6L; LocalPresetIndex out 4L; GetLocalPresetCoeffcients out L; LocalTxCoefficientsValid in L; LF, FS out 6L; RxEqEval, InvalidRequest out L; LinkEvaluationFeedbackDirectionChange in 6L (ignored).
REQ-009 LPIF ports SHALL be: pl_trdy out; lp_irdy in; lp_data in 512; lp_valid in 64 (byte valids); pl_data out 512; pl_valid out 64; lp_state_req in 4; pl_state_sts out 4; pl_speedmode out 3; lp_force_detect in.
REQ-010 Framing/message ports SHALL be: lp_dlpstart, lp_dlpend, lp_tlpstart, lp_tlpend in 64 (ignored); pl_dlpstart, pl_dlpend, pl_tlpstart, pl_tlpend, pl_tlpedb out 64; pl_linkUp out; M2P_MessageBus out 8 (0); P2M_MessageBus in 8 (ignored); RxStandby out 16 (0).

Function
REQ-011 LTSSM states SHALL be: DETECT, POLLING, CONFIG, SPEED, EQ, L0, all registered on CLK.
REQ-012 DETECT SHALL drive TxDetectRx_Loopback all ones, TxElecIdle all ones, PowerDown 4'd2 per lane, and go to POLLING when PhyStatus all ones and every RxStatus lane equals 3'b011.
REQ-013 POLLING SHALL drive each lane TxData 32'h4A4A4ABC (TS1) with TxDataK lane bits 4'b0001, and go to CONFIG after 8 consecutive cycles with every RxData lane equal to TS1.
REQ-014 CONFIG SHALL send TS2 32'h454545BC, and after 8 consecutive all-lane TS2 receptions go to SPEED if MAX_GEN>1, else toward L0.
REQ-015 SPEED SHALL set Rate and PCLKRate to MAX_GEN-1, pulse PclkChangeAck for one cycle, and go to EQ after 4 cycles.
REQ-016 EQ SHALL drive GetLocalPresetCoeffcients all ones and LocalPresetIndex 4'd4 per lane; when LocalTxCoefficientsValid is all ones it SHALL latch TxDeemph, LF and FS from LocalTxPresetCoefficients, LocalLF and LocalFS, pulse RxEqEval all ones for one cycle, then deassert GetLocalPresetCoeffcients.
REQ-017 Entry into L0 SHALL require lp_state_req==1; otherwise the block SHALL wait in the preceding state.
REQ-018 In L0: pl_linkUp=1, pl_state_sts=1, pl_trdy=1, pl_speedmode=Rate[2:0]; outside L0: pl_linkUp=0, pl_state_sts=0, pl_trdy=0.
REQ-019 In L0, lp_force_detect=1 or lp_state_req==2 SHALL send the state to DETECT next cycle; lp_force_detect SHALL take priority over data.
REQ-020 Tx path: a beat accepted with lp_irdy&&pl_trdy SHALL, 1 cycle later, drive TxData=lp_data, TxDataK=lp_valid, TxDataValid/TxStartBlock all ones and TxSyncHeader 2'b10 per lane; idle L0 cycles SHALL drive zeros.
REQ-021 Rx path: in L0, when RxDataValid and RxStartBlock are all ones, the block SHALL, 1 cycle later, drive pl_data=RxData, pl_valid=RxDataK, pl_tlpstart one-hot at the lowest set RxDataK bit and pl_tlpend one-hot at the highest; otherwise pl_valid, pl_tlpstart and pl_tlpend SHALL be 0.
REQ-022 pl_dlpstart, pl_dlpend, pl_tlpedb and InvalidRequest SHALL always be 0; TxElecIdle SHALL be 0 outside DETECT; PowerDown SHALL be 0 outside DETECT.

Reset
REQ-023 Reset SHALL force DETECT, with Rate=PCLKRate=0, pl_speedmode=0, pl_linkUp=0, pl_trdy=0, pl_state_sts=0, TxDeemph/LF/FS=0, all Tx data, valid and framing outputs 0, TxElecIdle all ones, and TxDetectRx_Loopback 0 during reset, asserting 1 cycle after release; reset mid-L0 SHALL drop the link immediately.

Configuration
REQ-024 With macro PCIE_EQ_EN defined, the EQ state SHALL be present; without it, SPEED SHALL proceed directly to L0 gating, GetLocalPresetCoeffcients and RxEqEval SHALL stay 0, and TxDeemph, LF and FS SHALL stay 0.

Verification
REQ-025 Reset for 3 cycles -> pl_state_sts=0, pl_linkUp=0, TxElecIdle=16'hFFFF, Rate=0.
REQ-026 Release reset, PhyStatus=16'hFFFF, RxStatus={16{3'b011}} -> TxData lanes=32'h4A4A4ABC, and TS2 follows 8 cycles after loopback TS1 reception.
REQ-027 MAX_GEN=5 with PCIE_EQ_EN, LocalTxCoefficientsValid all ones and all-ones coefficients -> TxDeemph, LF and FS all ones, then pl_linkUp=1, pl_speedmode=4, pl_state_sts=1.
REQ-028 L0 with Tx looped to Rx, one lp_irdy beat, random lp_data, lp_valid=64'h3FFFFFFFFFFFFFFF -> 2 cycles later pl_data=lp_data, pl_valid equal to lp_valid, pl_tlpstart=bit0, pl_tlpend=bit61.
REQ-029 lp_force_detect=1 in L0 -> next cycle pl_linkUp=0, TxDetectRx_Loopback=16'hFFFF.
REQ-030 Build without PCIE_EQ_EN -> GetLocalPresetCoeffcients stays 0 and the link still reaches L0.
